// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and sizes for the UART transmit arbiter
package uart_tx_arbiter_pkg;
  localparam int NREQ = 4;
  localparam int REQ_W = 2;
  localparam int TMO_W = 16;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAITBUSY = 3'd2,
    SEND     = 3'd3,
    HOLD     = 3'd4
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker, search starts at ptr
module rr_pick4
  import uart_tx_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [REQ_W-1:0] ptr,
  output logic             valid,
  output logic [REQ_W-1:0] winner
);
  assign valid = |req;
  // scan farthest-first so the nearest requester after ptr is the last write
  always_comb begin
    winner = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      winner = req[ptr + REQ_W'(k)] ? ptr + REQ_W'(k) : winner;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding one UART transmitter, with message locking
// Define UART_TX_ARBITER_TIMEOUT_EN to abandon a HOLD after TIMEOUT_CYC cycles without the owner's byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                sysclk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_last,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  output logic                txstart,
  output logic [7:0]          tx_data,
  input  logic                txbusy,
  output logic [REQ_W-1:0]    owner,
  output logic                locked,
  output logic                arb_busy,
  output logic                timeout_err
);
  state_t state;
  logic [REQ_W-1:0] ptr, win, w;
  logic valid, last_q, cap;
  rr_pick4 u_pick (.req(req), .ptr(ptr), .valid(valid), .winner(win));
  assign w = state == HOLD ? owner : win;
  assign cap = state == HOLD ? req[owner] : state == IDLE && valid;
  assign arb_busy = state != IDLE;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge sysclk) cnt <= (!reset_n || state != HOLD || cap) ? '0 : cnt + 1'b1;
`endif
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      tx_data <= '0;
      last_q <= 1'b0;
      ack <= '0;
      txstart <= 1'b0;
      locked <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack <= '0;
      txstart <= 1'b0;
      timeout_err <= 1'b0;
      if (cap) begin
        tx_data <= req_data[8*w +: 8];
        last_q <= req_last[w];
        owner <= w;
        ack <= 4'b0001 << w;
        state <= START;
      end else begin
        case (state)
          START: begin
            txstart <= 1'b1;
            state <= WAITBUSY;
          end
          WAITBUSY: state <= txbusy ? SEND : WAITBUSY;
          SEND: if (!txbusy) begin
            state <= last_q ? IDLE : HOLD;
            ptr <= last_q ? owner + 1'b1 : ptr;
            locked <= !last_q;
          end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          HOLD: if (cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            state <= IDLE;
            ptr <= owner + 1'b1;
            locked <= 1'b0;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0, req_last = '0;
  logic [31:0] req_data = '0;
  logic txbusy = 1'b0;
  logic [3:0] ack;
  logic txstart, locked, arb_busy, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  int m_ptr, m_owner, frames_done, x_state, x_cnt, x_len, starve;
  bit m_locked, m_frame, m_last, exp_txstart, end_pend, tmo_phase;
  logic [7:0] m_byte;
  logic [3:0] acked;
  int grants[$];
  int r_gap[4];

  uart_tx_arbiter #(.TIMEOUT_CYC(8)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .req(req), .req_last(req_last), .req_data(req_data),
    .ack(ack), .txstart(txstart), .tx_data(tx_data), .txbusy(txbusy), .owner(owner),
    .locked(locked), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic monitor();
    int w;
    chk("txstart", txstart, exp_txstart);
    exp_txstart = 0;
    if (!tmo_phase) chk("timeout_err", timeout_err, 0);
    if (end_pend) begin
      end_pend = 0;
      chk("locked_after", locked, !m_last);
      chk("busy_after", arb_busy, !m_last);
      m_locked = !m_last;
      if (m_last) m_ptr = (m_owner + 1) % 4;
      m_frame = 0;
      frames_done++;
    end
    acked = ack;
    if (ack != 0) begin
      w = m_locked ? m_owner : pick(req, m_ptr);
      if (w < 0 || !req[w]) chk("ack_spurious", ack, 0);
      else begin
        chk("ack", ack, 32'd1 << w);
        chk("owner", owner, w);
        chk("tx_data", tx_data, req_data[8*w +: 8]);
        chk("locked_cap", locked, m_locked);
        m_owner = w;
        m_byte = req_data[8*w +: 8];
        m_last = req_last[w];
        m_frame = 1;
        exp_txstart = 1;
        grants.push_back(w);
      end
    end else if (m_frame) chk("tx_hold", tx_data, m_byte);
  endtask

  task automatic xmit();
    if (txstart) begin
      x_state = 1;
      x_cnt = $urandom_range(0, 2);
    end
    if (x_state == 1) begin
      if (x_cnt == 0) begin
        txbusy = 1;
        x_len = $urandom_range(1, 5);
        x_state = 2;
      end else x_cnt--;
    end else if (x_state == 2) begin
      if (x_len == 0) begin
        txbusy = 0;
        x_state = 0;
        end_pend = 1;
      end else x_len--;
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
    monitor();
    xmit();
  endtask

  task automatic do_reset();
    reset_n = 0;
    req = '0;
    req_last = '0;
    req_data = '0;
    txbusy = 0;
    x_state = 0;
    m_ptr = 0;
    m_owner = 0;
    m_locked = 0;
    m_frame = 0;
    m_last = 0;
    exp_txstart = 0;
    end_pend = 0;
    acked = '0;
    r_gap = '{default: 0};
    grants.delete();
    step();
    chk("rst_ack", ack, 0);
    chk("rst_txstart", txstart, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_timeout", timeout_err, 0);
    reset_n = 1;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int start = frames_done;
    for (int c = 0; c < 100 && frames_done < start + n; c++) step();
    chk(tag, frames_done - start, n);
  endtask

  task automatic drive_rand();
    if (ack != 0 || req == 0) starve = 0;
    else starve++;
    if (starve > 80) begin
      chk("starve", 0, 1);
      starve = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (acked[i]) begin
        req[i] = 0;
        r_gap[i] = req_last[i] ? $urandom_range(0, 10) : $urandom_range(0, 4);
      end
      if (!req[i]) begin
        if (r_gap[i] == 0) begin
          req[i] = 1;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i] = $urandom_range(0, 2) != 0;
        end else r_gap[i]--;
      end
    end
  endtask

  initial begin
    int exp_c[5] = '{0, 1, 2, 3, 0};
    int exp_l[3] = '{2, 2, 0};
    tmo_phase = 0;
    frames_done = 0;
    starve = 0;
    do_reset();
    // single byte, minimum latency, pointer advance
    req = 4'b0001;
    req_data[7:0] = 8'h55;
    req_last = 4'b0001;
    step();
    chk("s_ack", ack, 4'b0001);
    req = 0;
    step();
    chk("s_txstart", txstart, 1);
    chk("s_ack_off", ack, 0);
    chk("s_data", tx_data, 8'h55);
    wait_frames(1, "s_done");
    chk("s_idle", arb_busy, 0);
    req = 4'b0011;
    req_last = 4'b0011;
    step();
    chk("s_ptr1", ack, 4'b0010);
    req = 0;
    wait_frames(1, "s_done2");
    // contention from reset
    do_reset();
    req = 4'hF;
    req_last = 4'hF;
    req_data = 32'h44332211;
    for (int c = 0; c < 300 && grants.size() < 5; c++) step();
    req = 0;
    chk("c_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("c_order", grants[i], exp_c[i]);
    wait_frames(1, "c_drain");
    // locked two-byte message with a competing requester
    do_reset();
    req = 4'b0100;
    req_data[23:16] = 8'hA1;
    step();
    chk("l_first", ack, 4'b0100);
    req_data[23:16] = 8'hA2;
    req_last[2] = 1;
    req[0] = 1;
    req_data[7:0] = 8'h33;
    req_last[0] = 1;
    wait_frames(1, "l_f1");
    chk("l_locked", locked, 1);
    for (int c = 0; c < 100 && grants.size() < 3; c++) begin
      step();
      if (ack[2]) req[2] = 0;
      if (ack[0]) req[0] = 0;
    end
    chk("l_count", grants.size(), 3);
    for (int i = 0; i < 3 && i < grants.size(); i++) chk("l_order", grants[i], exp_l[i]);
    wait_frames(1, "l_drain");
    chk("l_unlocked", locked, 0);
    // reset while the frame is in SEND
    do_reset();
    req = 4'b1000;
    req_data[31:24] = 8'h9C;
    req_last = 4'b1000;
    step();
    req = 0;
    for (int c = 0; c < 20 && x_state != 2; c++) step();
    step();
    chk("r_in_send", arb_busy, 1);
    chk("r_data", tx_data, 8'h9C);
    do_reset();
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    begin
      int k = 0;
      req = 4'b0010;
      req_data[15:8] = 8'h7E;
      step();
      req = 0;
      wait_frames(1, "t_hold");
      chk("t_locked", locked, 1);
      tmo_phase = 1;
      while (k < 20 && !timeout_err) begin
        step();
        k++;
      end
      chk("t_cycles", k, 8);
      chk("t_idle", arb_busy, 0);
      chk("t_unlock", locked, 0);
      step();
      chk("t_pulse", timeout_err, 0);
      tmo_phase = 0;
      m_locked = 0;
      m_ptr = 2;
      req = 4'hF;
      req_last = 4'hF;
      step();
      chk("t_ptr2", ack, 4'b0100);
      req = 0;
      wait_frames(1, "t_drain");
    end
    do_reset();
`endif
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      drive_rand();
    end
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
